// File: rtl/rv32_wb_unit_if.sv
// Handshake and write-port bundle between the issue/ALU/LSU side and the
// writeback unit. The unit itself connects through the slave modport.
interface rv32_wb_unit_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_val;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [4:0]        lsu_rd;
  logic [DATA_W-1:0] lsu_val;
  logic              iss_long;
  logic [4:0]        iss_rd;
  logic [4:0]        iss_rs1;
  logic [4:0]        iss_rs2;
  logic              hazard;
  logic              wb_en;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_val;

  modport master (
    output alu_valid, alu_rd, alu_val,
    output lsu_valid, lsu_rd, lsu_val,
    output iss_long, iss_rd, iss_rs1, iss_rs2,
    input  alu_ready, lsu_ready, hazard,
    input  wb_en, wb_reg, wb_val
  );

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  lsu_valid, lsu_rd, lsu_val,
    input  iss_long, iss_rd, iss_rs1, iss_rs2,
    output alu_ready, lsu_ready, hazard,
    output wb_en, wb_reg, wb_val
  );
endinterface

// File: rtl/rv32_wb_unit.sv
// Register-file writeback arbiter: single-cycle ALU results take priority, LSU
// results queue in a 2-entry FIFO, and a pending scoreboard raises issue hazards.
module rv32_wb_unit #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  rv32_wb_unit_if.slave bus
);
  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] val;
  } res_t;

  res_t              fifo_mem [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  logic [31:0]       pend;
  logic [31:0]       pend_nxt;
  logic              full;
  logic              push;
  logic              pop;
  res_t              head_ent;

  logic              take_p0;
  res_t              sel_p0;

  logic              vld_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] val_p1;

  assign full          = (count == 2'd2);
  assign bus.lsu_ready = !full;
  assign bus.alu_ready = !full;
  assign push          = bus.lsu_valid && !full;
  assign head_ent      = fifo_mem[head];

  // A full FIFO blocks the ALU, so the head always drains when the ALU is idle or stalled.
  assign pop = (count != 2'd0) && !(bus.alu_valid && !full);

  assign bus.hazard = pend[bus.iss_rs1] | pend[bus.iss_rs2] | pend[bus.iss_rd];

  // Clear first so that a same-cycle set of the same bit wins.
  always_comb begin
    pend_nxt = pend;
    if (pop) pend_nxt[head_ent.rd] = 1'b0;
    if (bus.iss_long && (bus.iss_rd != 5'd0)) pend_nxt[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= '{rd: bus.lsu_rd, val: bus.lsu_val};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      pend  <= '0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
      pend  <= pend_nxt;
    end
  end

  // Stage p0: pick the result that owns the write port this cycle.
  always_comb begin
    take_p0 = 1'b0;
    sel_p0  = head_ent;
    if (bus.alu_valid && !full) begin
      take_p0 = 1'b1;
      sel_p0  = '{rd: bus.alu_rd, val: bus.alu_val};
    end else if (pop) begin
      take_p0 = 1'b1;
    end
  end

  // Stage p1: registered register-file write port; x0 writes are suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      rd_p1  <= '0;
      val_p1 <= '0;
    end else if (take_p0) begin
      vld_p1 <= (sel_p0.rd != 5'd0);
      rd_p1  <= sel_p0.rd;
      val_p1 <= sel_p0.val;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.wb_en  = vld_p1;
  assign bus.wb_reg = rd_p1;
  assign bus.wb_val = val_p1;
endmodule
